count_sequence_checker: RTL

//  Sink-side monitor for the modulo-(N+1) up/down counter stream.
//  - Samples the count value on each valid cycle and infers the count direction.
//  - Locks onto the sequence, then flags wrap-arounds and broken steps (errors).
//  - Sits downstream of the counter; used in-system and as a bench scoreboard.

---
 rtl/count_sequence_checker_if.sv | 24 ++
 rtl/count_sequence_checker.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/count_sequence_checker_if.sv
// Sample/status bundle between a counter stream source and count_sequence_checker.
// The master drives samples; the slave (the checker) returns lock and error status.
interface count_sequence_checker_if #(
  parameter int NUM_BITS = 4
);
  logic                valid;
  logic [NUM_BITS-1:0] count_in;
  logic                locked;
  logic                dir_down;
  logic                wrap_pulse;
  logic                err_pulse;
  logic [7:0]          err_count;
  logic [NUM_BITS-1:0] last_count;

  modport master (
    output valid, count_in,
    input  locked, dir_down, wrap_pulse, err_pulse, err_count, last_count
  );

  modport slave (
    input  valid, count_in,
    output locked, dir_down, wrap_pulse, err_pulse, err_count, last_count
  );
endinterface

// File: rtl/count_sequence_checker.sv
// Monitor for a modulo-(N+1) up/down counter stream: locks onto the direction, flags wraps and broken steps.
// Optional build macro CHECKER_HOLD_OK_EN: a repeated value while locked is accepted as a stall.
module count_sequence_checker #(
  parameter int NUM_BITS   = 4,
  parameter int N          = 15,
  parameter int LOCK_COUNT = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  count_sequence_checker_if.slave chk
);

  localparam int            EW     = NUM_BITS + 1;
  localparam logic [EW-1:0] N_E    = EW'(N);
  localparam logic [EW-1:0] MOD_E  = EW'(N + 1);
  localparam logic [2:0]    LOCK_Q = 3'(LOCK_COUNT);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t              state_q, state_d;
  logic [2:0]          streak_q, streak_d;
  logic                cand_vld_q, cand_vld_d;
  logic                cand_down_q, cand_down_d;
  logic                locked_q, locked_d;
  logic                dir_down_q, dir_down_d;
  logic                wrap_q, wrap_d;
  logic                err_q, err_d;
  logic [7:0]          err_count_q, err_count_d;
  logic [NUM_BITS-1:0] last_count_q, last_count_d;

  logic [EW-1:0] prev_e, in_e, up_nxt, dn_nxt;
  logic          up_hit, dn_hit, exp_hit, hold_ok;

  // Step arithmetic one bit wider than the count so prev+N cannot overflow.
  always_comb begin
    prev_e  = {1'b0, last_count_q};
    in_e    = {1'b0, chk.count_in};
    up_nxt  = (prev_e + EW'(1)) % MOD_E;
    dn_nxt  = (prev_e + N_E) % MOD_E;
    up_hit  = (in_e <= N_E) && (in_e == up_nxt);
    dn_hit  = (in_e <= N_E) && (in_e == dn_nxt);
    exp_hit = dir_down_q ? dn_hit : up_hit;
`ifdef CHECKER_HOLD_OK_EN
    hold_ok = (chk.count_in == last_count_q);
`else
    hold_ok = 1'b0;
`endif
  end

  always_comb begin
    state_d      = state_q;
    streak_d     = streak_q;
    cand_vld_d   = cand_vld_q;
    cand_down_d  = cand_down_q;
    locked_d     = locked_q;
    dir_down_d   = dir_down_q;
    wrap_d       = 1'b0;
    err_d        = 1'b0;
    err_count_d  = err_count_q;
    last_count_d = last_count_q;
    if (chk.valid) begin
      unique case (state_q)
        EMPTY: begin
          last_count_d = chk.count_in;
          state_d      = SEARCH;
          streak_d     = 3'd0;
          cand_vld_d   = 1'b0;
        end
        SEARCH: begin
          last_count_d = chk.count_in;
          if (up_hit || dn_hit) begin
            cand_vld_d  = 1'b1;
            cand_down_d = !up_hit;
            streak_d    = (cand_vld_q && (cand_down_q == !up_hit)) ? streak_q + 3'd1 : 3'd1;
            if (streak_d == LOCK_Q) begin
              state_d    = LOCKED;
              locked_d   = 1'b1;
              dir_down_d = cand_down_d;
            end
          end else begin
            streak_d   = 3'd0;
            cand_vld_d = 1'b0;
          end
        end
        LOCKED: begin
          if (!hold_ok) begin
            if (exp_hit) begin
              last_count_d = chk.count_in;
              wrap_d       = dir_down_q ? (in_e == N_E) : (in_e == '0);
            end else begin
              // Resync from the offending sample so a new direction can relock quickly.
              err_d        = 1'b1;
              err_count_d  = sat_inc(err_count_q);
              locked_d     = 1'b0;
              state_d      = SEARCH;
              streak_d     = 3'd0;
              cand_vld_d   = 1'b0;
              last_count_d = chk.count_in;
            end
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= EMPTY;
      streak_q     <= 3'd0;
      cand_vld_q   <= 1'b0;
      cand_down_q  <= 1'b0;
      locked_q     <= 1'b0;
      dir_down_q   <= 1'b0;
      wrap_q       <= 1'b0;
      err_q        <= 1'b0;
      err_count_q  <= 8'd0;
      last_count_q <= '0;
    end else begin
      state_q      <= state_d;
      streak_q     <= streak_d;
      cand_vld_q   <= cand_vld_d;
      cand_down_q  <= cand_down_d;
      locked_q     <= locked_d;
      dir_down_q   <= dir_down_d;
      wrap_q       <= wrap_d;
      err_q        <= err_d;
      err_count_q  <= err_count_d;
      last_count_q <= last_count_d;
    end
  end

  assign chk.locked     = locked_q;
  assign chk.dir_down   = dir_down_q;
  assign chk.wrap_pulse = wrap_q;
  assign chk.err_pulse  = err_q;
  assign chk.err_count  = err_count_q;
  assign chk.last_count = last_count_q;

endmodule
